multicycle_controller: RTL and testbench
========================================

Name:
multicycle_controller

Overview:
- Multicycle sequencer for the MIPS datapath. Replaces single-cycle combinational control so one shared ALU and one unified memory port are reused across cycles.
- Decodes op/funct from the instruction register and steps through a Moore FSM.
- Emits datapath selects and enables, waits on a memory ready handshake, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  store strobe
- iord  out  1  0: address=PC; 1: address=ALUOut
- irwrite  out  1  load instruction register
- pcen  out  1  PC load enable
- pcsrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- alusrca  out  1  0 PC, 1 register A
- alusrcb  out  2  00 reg B, 01 constant 4, 10 signimm, 11 signimm<<2
- alucontrol  out  3  to ALU
- regdst  out  1  1: rd, 0: rt
- memtoreg  out  1  1: data register, 0: ALUOut
- regwrite  out  1  register file write
- state  out  4  current state encoding (debug)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and return to FETCH.
- Reset (reset==0 at posedge): state=FETCH, instret=0. Reset mid-instruction abandons it with no counter update.
- Outputs are Moore (decoded from state), except pcen, irwrite and memwrite, which also depend on mem_ready/zero as below. Unlisted outputs are 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop add, pcsrc=00.
  - irwrite and pcen are asserted only in the cycle mem_ready=1, then the FSM goes to DECODE.
  - With mem_ready=0 the FSM holds FETCH.
- DECODE: alusrca=0, alusrcb=11, add.
  - Next state by op: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other op -> FETCH without counting.
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Holds until mem_ready, then -> FETCH.
- EXEC: alusrca=1, alusrcb=00, funct decode -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- alucontrol encodings: add=010, sub=110. In EXEC, funct maps 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; other funct -> 010.
- instret increments by 1 on the transition out of MEMWB, MEMWR (when mem_ready=1), ALUWB, BRANCH, ADDIWB and JUMP. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Optional Feature:
- Macro: MCCTRL_BNE_EN.
- Defined: op 000101 in DECODE -> BRANCH. BRANCH latches bne-ness in a 1-bit register written in DECODE and uses pcen = zero XOR isbne. beq behaviour is unchanged.
- Undefined: op 000101 is unsupported (DECODE -> FETCH, not counted) and the isbne register is absent.

Test Plan:
- Reset held low 2 cycles, then released with mem_ready=1 -> state=0, instret=0, pcen=0 during reset; first fetch cycle shows irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op 100011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4; instret +1 after 5 cycles.
- sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles; instret increments only on the ready cycle; fetch stall of 2 cycles holds irwrite=0, pcen=0.
- R-type op 000000 with funct 101010, then 100100 -> EXEC alucontrol=111, then 000; ALUWB regdst=1, regwrite=1.
- beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; with zero=0 -> pcen=0; j -> pcsrc=10, pcen=1. Under MCCTRL_BNE_EN, op 000101 with zero=0 -> pcen=1.
- Illegal op 111111 -> DECODE->FETCH, instret unchanged. Reset asserted in MEMRD -> next state FETCH, instret=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle sequencer (master) and the MIPS datapath (slave).
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             memwrite;
    logic             iord;
    logic             irwrite;
    logic             pcen;
    logic [1:0]       pcsrc;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [2:0]       alucontrol;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, state, instret
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, state, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory-ready handshake and retired-instruction counter.
// Optional MCCTRL_BNE_EN adds bne support through the BRANCH state.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_controller_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t           st, nxt;
    logic [CNT_W-1:0] cnt;
    logic             retire;
    logic             pcen_raw, irwrite_raw, memwrite_raw;
    logic             br_take;

`ifdef MCCTRL_BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
    logic isbne;

    always_ff @(posedge clk) begin
        if (!reset)
            isbne <= 1'b0;
        else if (st == DECODE)
            isbne <= (bus.op == OP_BNE);
    end

    assign br_take = bus.zero ^ isbne;
`else
    assign br_take = bus.zero;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (retire)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nxt             = FETCH;
        retire          = 1'b0;
        pcen_raw        = 1'b0;
        irwrite_raw     = 1'b0;
        memwrite_raw    = 1'b0;
        bus.mem_req     = 1'b0;
        bus.iord        = 1'b0;
        bus.pcsrc       = 2'b00;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.alucontrol  = 3'b000;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regwrite    = 1'b0;
        case (st)
            FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alusrcb    = 2'b01;
                bus.alucontrol = ALU_ADD;
                irwrite_raw    = bus.mem_ready;
                pcen_raw       = bus.mem_ready;
                nxt            = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.alucontrol = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RT:        nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
`ifdef MCCTRL_BNE_EN
                    OP_BNE:       nxt = BRANCH;
`endif
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = ALU_ADD;
                nxt            = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                nxt         = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
                retire       = bus.mem_ready;
                nxt          = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                bus.alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: bus.alucontrol = ALU_SUB;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = ALU_ADD;
                endcase
                nxt = ALUWB;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = ALU_SUB;
                bus.pcsrc      = 2'b01;
                pcen_raw       = br_take;
                retire         = 1'b1;
            end
            ADDIEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = ALU_ADD;
                nxt            = ADDIWB;
            end
            ADDIWB: begin
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            JUMP: begin
                bus.pcsrc = 2'b10;
                pcen_raw  = 1'b1;
                retire    = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

    // Architectural write strobes are suppressed while reset is held.
    assign bus.pcen     = pcen_raw & reset;
    assign bus.irwrite  = irwrite_raw & reset;
    assign bus.memwrite = memwrite_raw & reset;
    assign bus.state    = st;
    assign bus.instret  = cnt;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller: one row per clock cycle.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(32)) bus ();
    multicycle_controller #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic        pcen;
        logic        irw;
        logic        mw;
        logic [2:0]  alu;
        logic [31:0] cnt;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, BNE = 6'b000101, ILL = 6'b111111;

    vec_t q[$];

    function automatic vec_t row(logic rst, logic [5:0] op, logic [5:0] funct, logic zero, logic rdy,
                                 logic [3:0] st, logic pcen, logic irw, logic mw, logic [2:0] alu,
                                 logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.funct = funct; v.zero = zero; v.rdy = rdy;
        v.st = st; v.pcen = pcen; v.irw = irw; v.mw = mw; v.alu = alu; v.cnt = cnt;
        return v;
    endfunction

    // Expected {mem_req, iord, pcsrc, alusrca, alusrcb, regdst, memtoreg, regwrite} per state.
    function automatic logic [9:0] moore(logic [3:0] s);
        case (s)
            4'd0:    return 10'b1_0_00_0_01_0_0_0;
            4'd1:    return 10'b0_0_00_0_11_0_0_0;
            4'd2:    return 10'b0_0_00_1_10_0_0_0;
            4'd3:    return 10'b1_1_00_0_00_0_0_0;
            4'd4:    return 10'b0_0_00_0_00_0_1_1;
            4'd5:    return 10'b1_1_00_0_00_0_0_0;
            4'd6:    return 10'b0_0_00_1_00_0_0_0;
            4'd7:    return 10'b0_0_00_0_00_1_0_1;
            4'd8:    return 10'b0_0_01_1_00_0_0_0;
            4'd9:    return 10'b0_0_00_1_10_0_0_0;
            4'd10:   return 10'b0_0_00_0_00_0_0_1;
            4'd11:   return 10'b0_0_10_0_00_0_0_0;
            default: return 10'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] snap();
        return {12'b0, bus.state, bus.pcen, bus.irwrite, bus.memwrite, bus.alucontrol,
                bus.mem_req, bus.iord, bus.pcsrc, bus.alusrca, bus.alusrcb,
                bus.regdst, bus.memtoreg, bus.regwrite, bus.instret};
    endfunction

    initial begin
        logic [31:0] base;
        reset = 1'b0; bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // reset, then lw
        q.push_back(row(0, LW, 0, 0, 1, 0, 0, 0, 0, 3'b010, 0));
        q.push_back(row(1, LW, 0, 0, 1, 0, 1, 1, 0, 3'b010, 0));
        q.push_back(row(1, LW, 0, 0, 1, 1, 0, 0, 0, 3'b010, 0));
        q.push_back(row(1, LW, 0, 0, 1, 2, 0, 0, 0, 3'b010, 0));
        q.push_back(row(1, LW, 0, 0, 1, 3, 0, 0, 0, 3'b000, 0));
        q.push_back(row(1, LW, 0, 0, 1, 4, 0, 0, 0, 3'b000, 0));
        // sw with 2-cycle fetch stall and 3-cycle store stall
        q.push_back(row(1, SW, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1));
        q.push_back(row(1, SW, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1));
        q.push_back(row(1, SW, 0, 0, 1, 0, 1, 1, 0, 3'b010, 1));
        q.push_back(row(1, SW, 0, 0, 1, 1, 0, 0, 0, 3'b010, 1));
        q.push_back(row(1, SW, 0, 0, 1, 2, 0, 0, 0, 3'b010, 1));
        q.push_back(row(1, SW, 0, 0, 0, 5, 0, 0, 1, 3'b000, 1));
        q.push_back(row(1, SW, 0, 0, 0, 5, 0, 0, 1, 3'b000, 1));
        q.push_back(row(1, SW, 0, 0, 0, 5, 0, 0, 1, 3'b000, 1));
        q.push_back(row(1, SW, 0, 0, 1, 5, 0, 0, 1, 3'b000, 1));
        // R-type slt then and
        q.push_back(row(1, RT, 6'b101010, 0, 1, 0, 1, 1, 0, 3'b010, 2));
        q.push_back(row(1, RT, 6'b101010, 0, 1, 1, 0, 0, 0, 3'b010, 2));
        q.push_back(row(1, RT, 6'b101010, 0, 1, 6, 0, 0, 0, 3'b111, 2));
        q.push_back(row(1, RT, 6'b101010, 0, 1, 7, 0, 0, 0, 3'b000, 2));
        q.push_back(row(1, RT, 6'b100100, 0, 1, 0, 1, 1, 0, 3'b010, 3));
        q.push_back(row(1, RT, 6'b100100, 0, 1, 1, 0, 0, 0, 3'b010, 3));
        q.push_back(row(1, RT, 6'b100100, 0, 1, 6, 0, 0, 0, 3'b000, 3));
        q.push_back(row(1, RT, 6'b100100, 0, 1, 7, 0, 0, 0, 3'b000, 3));
        // beq taken / not taken
        q.push_back(row(1, BEQ, 0, 1, 1, 0, 1, 1, 0, 3'b010, 4));
        q.push_back(row(1, BEQ, 0, 1, 1, 1, 0, 0, 0, 3'b010, 4));
        q.push_back(row(1, BEQ, 0, 1, 1, 8, 1, 0, 0, 3'b110, 4));
        q.push_back(row(1, BEQ, 0, 0, 1, 0, 1, 1, 0, 3'b010, 5));
        q.push_back(row(1, BEQ, 0, 0, 1, 1, 0, 0, 0, 3'b010, 5));
        q.push_back(row(1, BEQ, 0, 0, 1, 8, 0, 0, 0, 3'b110, 5));
        // j
        q.push_back(row(1, JMP, 0, 0, 1, 0, 1, 1, 0, 3'b010, 6));
        q.push_back(row(1, JMP, 0, 0, 1, 1, 0, 0, 0, 3'b010, 6));
        q.push_back(row(1, JMP, 0, 0, 1, 11, 1, 0, 0, 3'b000, 6));
        // addi
        q.push_back(row(1, ADDI, 0, 0, 1, 0, 1, 1, 0, 3'b010, 7));
        q.push_back(row(1, ADDI, 0, 0, 1, 1, 0, 0, 0, 3'b010, 7));
        q.push_back(row(1, ADDI, 0, 0, 1, 9, 0, 0, 0, 3'b010, 7));
        q.push_back(row(1, ADDI, 0, 0, 1, 10, 0, 0, 0, 3'b000, 7));
        // illegal op is dropped without counting
        q.push_back(row(1, ILL, 0, 0, 1, 0, 1, 1, 0, 3'b010, 8));
        q.push_back(row(1, ILL, 0, 0, 1, 1, 0, 0, 0, 3'b010, 8));
        // bne with zero=0
        q.push_back(row(1, BNE, 0, 0, 1, 0, 1, 1, 0, 3'b010, 8));
        q.push_back(row(1, BNE, 0, 0, 1, 1, 0, 0, 0, 3'b010, 8));
`ifdef MCCTRL_BNE_EN
        q.push_back(row(1, BNE, 0, 0, 1, 8, 1, 0, 0, 3'b110, 8));
        q.push_back(row(1, LW, 0, 0, 1, 0, 1, 1, 0, 3'b010, 9));
        base = 32'd9;
`else
        q.push_back(row(1, LW, 0, 0, 1, 0, 1, 1, 0, 3'b010, 8));
        base = 32'd8;
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < q.size(); i++) begin
            reset = q[i].rst; bus.op = q[i].op; bus.funct = q[i].funct;
            bus.zero = q[i].zero; bus.mem_ready = q[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), snap(),
                {12'b0, q[i].st, q[i].pcen, q[i].irw, q[i].mw, q[i].alu, moore(q[i].st), q[i].cnt});
            @(posedge clk);
            @(negedge clk);
        end

        // lw in progress: stall in MEMRD, then reset abandons it
        @(posedge clk); @(negedge clk);
        chk("lw_memadr_state", {60'b0, bus.state}, 64'd2);
        bus.mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("memrd_state", {60'b0, bus.state}, 64'd3);
        @(posedge clk); @(negedge clk);
        chk("memrd_hold", {60'b0, bus.state, bus.mem_req, bus.iord}, {58'b0, 4'd3, 2'b11});
        chk("memrd_cnt", {32'b0, bus.instret}, {32'b0, base});
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_in_memrd", {27'b0, bus.state, bus.pcen, bus.instret}, 64'd0);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("post_rst_fetch", {60'b0, bus.state, bus.irwrite, bus.pcen}, {58'b0, 4'd0, 2'b11});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
